seq_frame_sched: RTL
====================

# seq_frame_sched

Controller that sequences the 11011 Mealy sequence detector. It accepts parallel bytes over a valid/ready handshake and serializes them MSB-first into the detector under a per-bit enable strobe. It counts detector hits and raises an interrupt when a programmable hit threshold is reached. It sits between the pin-level input byte bus and the detector instance in the top-level wrapper.

## Interface
- DATA_W, 8, byte width; bits serialized per accepted word
- CNT_W, 8, hit counter and threshold width
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_data  in  DATA_W  word to serialize
- in_valid  in  1  in_data valid
- in_ready  out  1  controller can accept a word this cycle
- thresh  in  CNT_W  irq threshold; 0 disables irq
- clear  in  1  synchronous clear of hit_count
- irq_ack  in  1  acknowledges and clears irq
- det_bit  out  1  serial bit to detector
- det_en  out  1  detector advances this cycle; detector holds state when low
- det_hit  in  1  detector Mealy output, valid in the same cycle as det_en
- hit_count  out  CNT_W  saturating hit count
- irq  out  1  threshold reached; sticky until irq_ack
- busy  out  1  state != IDLE

## Operation
- States: IDLE, SHIFT, STALL.
- IDLE
  - in_ready=1.
  - On in_valid: load shreg<=in_data, bit_idx<=DATA_W-1, go to SHIFT.
- SHIFT
  - det_en=1, det_bit=shreg[DATA_W-1].
  - Each cycle: shreg<<=1, bit_idx--.
  - in_ready=1 only in the cycle with bit_idx==0 and no stall triggered; a handshake then reloads for back-to-back operation.
  - After the last bit with no new word: go to IDLE.
- Hit counting
  - When det_en && det_hit, hit_count<=hit_count+1, saturating at 2^CNT_W-1.
  - At saturation, further hits are ignored and cannot trigger irq.
- Threshold
  - If thresh!=0 and the incremented count equals thresh: irq<=1.
  - If bits of the current word remain, SHIFT goes to STALL.
  - If that hit was on the last bit, go to IDLE with in_ready forced to 0 in that cycle.
- STALL
  - det_en=0; shreg and bit_idx held; in_ready=0.
  - On irq_ack: irq<=0, return to SHIFT.
- irq_ack outside STALL clears irq and has no other effect.
- While irq=1 in IDLE, words are still accepted; a second threshold crossing is impossible until clear, because the count only rises.
- clear: hit_count<=0 next edge.
  - Clear together with a counted hit: clear wins, count=0, no irq from that hit.
  - Clear does not affect irq or the FSM.
- det_bit=0 whenever det_en=0.

## Timing
- Reset, async, in effect while rst=1:
  - state=IDLE, shreg=0, bit_idx=0, hit_count=0, irq=0.
  - in_ready=0 while rst=1.
  - det_en=0, det_bit=0, busy=0.
- Accept handshake at edge N: det_en high for cycles N+1..N+DATA_W, barring stall.
- hit_count and irq update at the edge closing the hit cycle; visible one cycle after det_hit.
- Stall triggered at the edge closing hit cycle H: det_en=0 from H+1 until the cycle after irq_ack is sampled.
- Back-to-back words: zero-bubble; det_en continuous across words.
- in_valid held with in_ready=0: no load; data must be held by the source.
- Reset mid-word: partial word discarded, detector not advanced.

## Test plan
- Reset, rst=1 for 3 cycles: all outputs 0, in_ready=0. After release, in_ready=1, busy=0.
- thresh=0, in_data=0xD8 accepted: det_bit over 8 det_en cycles = 1,1,0,1,1,0,0,0. Detector model hits on the 5th bit. hit_count=1, irq=0, in_ready=1 after 8 cycles.
- thresh=1, 0xD8: hit on the 5th bit sets irq. det_en drops for 3 held bits. Hold 4 cycles, then irq_ack: remaining bits 0,0,0 shifted, hit_count=1.
- Back-to-back 0xDB, 0x6C with in_valid held high: 16 contiguous det_en cycles with no bubble. Hit count follows the detector model with non-overlapping semantics.
- Saturation: force 255 hits, then one more: count stays 255, no irq with thresh=0.
- clear asserted in the same cycle as a hit: hit_count=0 next cycle, no irq.

Source files
------------

// File: rtl/seq_frame_sched.sv
// Serializes handshaked words MSB-first into an 11011 Mealy detector, counts its
// hits with saturation and raises a sticky threshold interrupt that can stall the stream.
module seq_frame_sched #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CNT_W-1:0]  thresh,
  input  logic              clear,
  input  logic              irq_ack,
  output logic              det_bit,
  output logic              det_en,
  input  logic              det_hit,
  output logic [CNT_W-1:0]  hit_count,
  output logic              irq,
  output logic              busy
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, STALL} state_t;

  state_t            state_q;
  logic [DATA_W-1:0] shreg_q;
  logic [IDX_W-1:0]  bit_idx_q;
  logic [CNT_W-1:0]  hit_count_q, hit_count_d;
  logic              irq_q, irq_d;

  logic             hit, cnt_inc, trig, last, accept;
  logic [CNT_W-1:0] cnt_plus;

  assign hit      = (state_q == SHIFT) && det_hit;
  assign cnt_inc  = hit && !(&hit_count_q);
  assign cnt_plus = hit_count_q + CNT_W'(1);
  // A hit swallowed by a simultaneous clear must not raise the interrupt.
  assign trig     = cnt_inc && !clear && (thresh != '0) && (cnt_plus == thresh);
  assign last     = (bit_idx_q == '0);

  assign in_ready  = !rst && ((state_q == IDLE) || ((state_q == SHIFT) && last && !trig));
  assign accept    = in_valid && in_ready;
  assign det_en    = (state_q == SHIFT);
  assign det_bit   = det_en && shreg_q[DATA_W-1];
  assign busy      = (state_q != IDLE);
  assign hit_count = hit_count_q;
  assign irq       = irq_q;

  always_comb begin
    hit_count_d = hit_count_q;
    if (clear)        hit_count_d = '0;
    else if (cnt_inc) hit_count_d = cnt_plus;
  end

  // A new threshold crossing takes priority over an acknowledge in the same cycle.
  always_comb begin
    irq_d = irq_q;
    if (irq_ack) irq_d = 1'b0;
    if (trig)    irq_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      bit_idx_q   <= '0;
      hit_count_q <= '0;
      irq_q       <= 1'b0;
    end else begin
      hit_count_q <= hit_count_d;
      irq_q       <= irq_d;
      case (state_q)
        IDLE: begin
          if (accept) begin
            shreg_q   <= in_data;
            bit_idx_q <= IDX_LAST;
            state_q   <= SHIFT;
          end
        end
        SHIFT: begin
          if (accept) begin
            shreg_q   <= in_data;
            bit_idx_q <= IDX_LAST;
          end else begin
            shreg_q <= {shreg_q[DATA_W-2:0], 1'b0};
            if (!last) bit_idx_q <= bit_idx_q - IDX_W'(1);
            if (trig && !last) state_q <= STALL;
            else if (last)     state_q <= IDLE;
          end
        end
        STALL: begin
          if (irq_ack) state_q <= SHIFT;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
